// File: rtl/tilt_pkg.sv
// rtl/tilt_pkg.sv - shared states, default parameters and duty clamp helper for tilt_duty_ctrl
package tilt_pkg;

    typedef enum logic [2:0] {
        S_PRIME = 3'd0,
        S_IDLE  = 3'd1,
        S_AVG   = 3'd2,
        S_EVAL  = 3'd3,
        S_APPLY = 3'd4
    } tilt_state_e;

    localparam int DEF_DUTY_INIT = 50;
    localparam int DEF_DUTY_MAX  = 100;
    localparam int DEF_STEP      = 5;
    localparam int DEF_DEADBAND  = 16;

    // 9-bit arithmetic so an up step never wraps before the clamp.
    function automatic logic [7:0] sat_step(input logic [7:0] duty, input logic up,
                                            input logic [7:0] step, input logic [7:0] max);
        logic [8:0] sum;
        sum = {1'b0, duty} + {1'b0, step};
        if (up)
            return (sum > {1'b0, max}) ? max : sum[7:0];
        else
            return (duty < step) ? 8'd0 : (duty - step);
    endfunction

endpackage

// File: rtl/tilt_avg4.sv
// rtl/tilt_avg4.sv - 4-tap moving average of accepted samples with preloadable history
module tilt_avg4 #(
    parameter int DATA_W = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     load,
    input  logic                     preload,
    input  logic signed [DATA_W-1:0] din,
    output logic signed [DATA_W-1:0] dout
);

    logic signed [DATA_W-1:0] hist [4];
    logic signed [DATA_W+1:0] sum;
    logic signed [DATA_W+1:0] din_ext;
    logic signed [DATA_W+1:0] old_ext;

    assign din_ext = {{2{din[DATA_W-1]}}, din};
    assign old_ext = {{2{hist[3][DATA_W-1]}}, hist[3]};

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 4; i++) hist[i] <= '0;
            sum <= '0;
        end else if (preload) begin
            for (int i = 0; i < 4; i++) hist[i] <= din;
            sum <= din_ext <<< 2;
        end else if (load) begin
            hist[0] <= din;
            for (int i = 1; i < 4; i++) hist[i] <= hist[i-1];
            sum <= sum + din_ext - old_ext;
        end
    end

    assign dout = DATA_W'(sum >>> 2);

endmodule

// File: rtl/tilt_duty_ctrl.sv
// rtl/tilt_duty_ctrl.sv - tilt sample to PWM duty stepper; TILT_DUTY_AVG_EN adds a 4-tap average stage
module tilt_duty_ctrl
    import tilt_pkg::*;
#(
    parameter int DATA_W    = 16,
    parameter int DUTY_INIT = DEF_DUTY_INIT,
    parameter int DUTY_MAX  = DEF_DUTY_MAX,
    parameter int STEP      = DEF_STEP,
    parameter int DEADBAND  = DEF_DEADBAND
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     enable,
    input  logic                     data_update,
    input  logic signed [DATA_W-1:0] data_x,
    output logic [7:0]               duty_cycle,
    output logic                     duty_valid,
    output logic                     dir_up,
    output logic                     at_limit,
    output logic                     overrun
);

    tilt_state_e state, state_n;

    logic signed [DATA_W-1:0] prev_x;
    logic signed [DATA_W-1:0] sample_q;
    logic signed [DATA_W:0]   delta;
    logic        [DATA_W:0]   mag;
    logic                     move, up, move_q, up_q;
    logic                     strobe, busy;

    assign strobe = data_update & enable;
    assign busy   = (state == S_AVG) || (state == S_EVAL) || (state == S_APPLY);

    // One extra bit of width keeps full-scale swings from overflowing.
    assign delta = {sample_q[DATA_W-1], sample_q} - {prev_x[DATA_W-1], prev_x};
    assign mag   = delta[DATA_W] ? unsigned'(-delta) : unsigned'(delta);
    assign move  = mag > (DATA_W+1)'(DEADBAND);
    assign up    = ~delta[DATA_W] && (delta != '0);

    assign at_limit = (duty_cycle == 8'd0) || (duty_cycle == 8'(DUTY_MAX));

`ifdef TILT_DUTY_AVG_EN
    logic signed [DATA_W-1:0] avg_out;

    tilt_avg4 #(.DATA_W(DATA_W)) u_avg (
        .clk     (clk),
        .reset   (reset),
        .load    ((state == S_IDLE) && strobe),
        .preload ((state == S_PRIME) && strobe),
        .din     (data_x),
        .dout    (avg_out)
    );
`endif

    always_ff @(posedge clk) begin
        if (reset) state <= S_PRIME;
        else       state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            S_PRIME: if (strobe) state_n = S_IDLE;
`ifdef TILT_DUTY_AVG_EN
            S_IDLE:  if (strobe) state_n = S_AVG;
`else
            S_IDLE:  if (strobe) state_n = S_EVAL;
`endif
            S_AVG:   state_n = S_EVAL;
            S_EVAL:  state_n = S_APPLY;
            S_APPLY: state_n = S_IDLE;
            default: state_n = S_PRIME;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            prev_x     <= '0;
            sample_q   <= '0;
            move_q     <= 1'b0;
            up_q       <= 1'b0;
            duty_cycle <= 8'(DUTY_INIT);
            duty_valid <= 1'b0;
            dir_up     <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            duty_valid <= 1'b0;
            if (busy && strobe) overrun <= 1'b1;
            case (state)
                S_PRIME: if (strobe) prev_x <= data_x;
`ifdef TILT_DUTY_AVG_EN
                S_AVG:   sample_q <= avg_out;
`else
                S_IDLE:  if (strobe) sample_q <= data_x;
`endif
                S_EVAL: begin
                    move_q <= move;
                    up_q   <= up;
                end
                S_APPLY: begin
                    duty_valid <= 1'b1;
                    // Baseline only advances on a real move so slow drift keeps accumulating.
                    if (move_q) begin
                        prev_x     <= sample_q;
                        dir_up     <= up_q;
                        duty_cycle <= sat_step(duty_cycle, up_q, 8'(STEP), 8'(DUTY_MAX));
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_tilt_duty_ctrl.sv
// tb/tb_tilt_duty_ctrl.sv - self-checking bench for tilt_duty_ctrl against a cycle-level reference model
module tb_tilt_duty_ctrl;

`ifdef TILT_DUTY_AVG_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 2;
`endif

    logic               clk = 1'b0;
    logic               reset, enable, data_update;
    logic signed [15:0] data_x;
    logic [7:0]         duty_cycle;
    logic               duty_valid, dir_up, at_limit, overrun;

    int checks = 0;
    int failures = 0;

    tilt_duty_ctrl dut (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
        .data_update (data_update),
        .data_x      (data_x),
        .duty_cycle  (duty_cycle),
        .duty_valid  (duty_valid),
        .dir_up      (dir_up),
        .at_limit    (at_limit),
        .overrun     (overrun)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: architectural result is computed at acceptance, then
    // revealed on the outputs LAT edges later.
    bit primed;
    int prev, m_duty, m_dir;
    int o_duty, o_dir, o_valid, o_ovr;
    int busy, pend;
    int hist[4];

    always @(posedge clk) begin
        int x, s, delta, mag;
        bit was_busy;
        o_valid = 0;
        if (reset) begin
            primed = 0; prev = 0; m_duty = 50; m_dir = 0;
            o_duty = 50; o_dir = 0; o_ovr = 0; busy = 0; pend = 0;
            for (int i = 0; i < 4; i++) hist[i] = 0;
        end else begin
            if (pend > 0) begin
                pend--;
                if (pend == 0) begin
                    o_valid = 1; o_duty = m_duty; o_dir = m_dir;
                end
            end
            was_busy = busy > 0;
            if (busy > 0) busy--;
            if (data_update && enable) begin
                x = int'(data_x);
                if (!primed) begin
                    primed = 1; prev = x;
                    for (int i = 0; i < 4; i++) hist[i] = x;
                end else if (was_busy) begin
                    o_ovr = 1;
                end else begin
`ifdef TILT_DUTY_AVG_EN
                    hist[3] = hist[2]; hist[2] = hist[1]; hist[1] = hist[0]; hist[0] = x;
                    s = (hist[0] + hist[1] + hist[2] + hist[3]) >>> 2;
`else
                    s = x;
`endif
                    delta = s - prev;
                    mag = (delta < 0) ? -delta : delta;
                    if (mag > 16) begin
                        prev = s;
                        m_dir = (delta > 0) ? 1 : 0;
                        if (delta > 0) m_duty = (m_duty + 5 > 100) ? 100 : m_duty + 5;
                        else           m_duty = (m_duty < 5) ? 0 : m_duty - 5;
                    end
                    busy = LAT; pend = LAT;
                end
            end
        end
    end

    always begin
        @(posedge clk);
        #1;
        chk("duty_cycle", 32'(duty_cycle), 32'(o_duty));
        chk("duty_valid", 32'(duty_valid), 32'(o_valid));
        chk("dir_up",     32'(dir_up),     32'(o_dir));
        chk("overrun",    32'(overrun),    32'(o_ovr));
        chk("at_limit",   32'(at_limit),   32'((o_duty == 0 || o_duty == 100) ? 1 : 0));
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic strobe(input int x);
        @(negedge clk);
        data_update = 1'b1;
        data_x = 16'(x);
        @(negedge clk);
        data_update = 1'b0;
    endtask

    task automatic do_reset;
        @(negedge clk);
        reset = 1'b1;
        idle(2);
        reset = 1'b0;
    endtask

    initial begin
        int last_x;
        reset = 1'b1; enable = 1'b1; data_update = 1'b0; data_x = '0;
        idle(3);
        reset = 1'b0;

`ifndef TILT_DUTY_AVG_EN
        // Baseline sample, then first real move.
        strobe(100); idle(4);
        chk("prime_duty", 32'(duty_cycle), 32'd50);
        strobe(200); idle(4);
        chk("first_move_duty", 32'(duty_cycle), 32'd55);
        chk("first_move_dir", 32'(dir_up), 32'd1);

        // Deadband: baseline must stay at 0, so 12 is still inside it.
        do_reset; strobe(0);
        strobe(10); idle(3); strobe(-10); idle(3); strobe(12); idle(4);
        chk("deadband_duty", 32'(duty_cycle), 32'd50);

        // Saturation both ways.
        do_reset; strobe(0);
        for (int i = 1; i <= 12; i++) begin strobe(100 * i); idle(3); end
        chk("sat_hi_duty", 32'(duty_cycle), 32'd100);
        chk("sat_hi_limit", 32'(at_limit), 32'd1);
        for (int i = 1; i <= 25; i++) begin strobe(1200 - 100 * i); idle(3); end
        chk("sat_lo_duty", 32'(duty_cycle), 32'd0);
        chk("sat_lo_limit", 32'(at_limit), 32'd1);

        // Back-to-back strobes: second dropped, overrun sticky.
        do_reset; strobe(0);
        @(negedge clk); data_update = 1'b1; data_x = 16'sd500;
        @(negedge clk); data_x = 16'sd900;
        @(negedge clk); data_update = 1'b0;
        idle(10);
        chk("overrun_set", 32'(overrun), 32'd1);
        chk("overrun_duty", 32'(duty_cycle), 32'd55);
        do_reset;
        chk("overrun_clear", 32'(overrun), 32'd0);

        // Full-scale swing.
        strobe(-32768); strobe(32767); idle(4);
        chk("extreme_duty", 32'(duty_cycle), 32'd55);
        chk("extreme_dir", 32'(dir_up), 32'd1);

        // Reset while the update is in S_EVAL.
        do_reset; strobe(0); strobe(1000); idle(3);
        strobe(2000);
        reset = 1'b1;
        @(negedge clk); reset = 1'b0;
        idle(4);
        chk("abort_duty", 32'(duty_cycle), 32'd50);
`else
        do_reset; strobe(0);
        for (int i = 0; i < 4; i++) begin strobe(400); idle(3); end
        chk("avg_duty", 32'(duty_cycle), 32'd70);
        chk("avg_dir", 32'(dir_up), 32'd1);
`endif

        // Enable low while busy: ignored, no overrun, update completes.
        do_reset; strobe(0);
        strobe(3000);
        enable = 1'b0; data_update = 1'b1; data_x = 16'sd9000;
        idle(6);
        data_update = 1'b0; enable = 1'b1;
        chk("enable_low_ovr", 32'(overrun), 32'd0);

        // Randomised traffic checked every cycle by the model.
        last_x = 0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            reset = ($urandom_range(0, 299) == 0);
            enable = ($urandom_range(0, 9) != 0);
            data_update = ($urandom_range(0, 9) < 4);
            if ($urandom_range(0, 3) == 0) last_x = int'($urandom_range(0, 65535)) - 32768;
            else last_x = last_x + int'($urandom_range(0, 100)) - 50;
            data_x = 16'(last_x);
        end
        @(negedge clk);
        reset = 1'b0; data_update = 1'b0;
        idle(6);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
